// File: rtl/inst_loader.sv
// Program loader: packs UART bytes big-endian into instruction words and
// writes them to instruction memory until a halt word, overflow or timeout.
module inst_loader #(
  parameter int unsigned          INST_SZ   = 32,
  parameter int unsigned          BYTE_SZ   = 8,
  parameter int unsigned          MEM_SZ    = 10,
  parameter logic [INST_SZ-1:0]   HALT_INST = 32'hFFFF_FFFF,
  parameter int unsigned          TIMEOUT   = 100000
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [BYTE_SZ-1:0] i_rx_data,
  input  logic               i_rx_done,
  output logic [INST_SZ-1:0] o_instruction,
  output logic               o_write,
  output logic [MEM_SZ-1:0]  o_addr,
  output logic [MEM_SZ:0]    o_word_count,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_error
);

  localparam int unsigned SR_W = INST_SZ - BYTE_SZ;
  localparam int unsigned TO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TIMEOUT - 1);
  localparam logic [MEM_SZ:0]   CAPACITY = {1'b1, {MEM_SZ{1'b0}}};

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    WRITE,
    DONE,
    ERROR
  } state_t;

  state_t state, state_next;

  // Only the lower three bytes of the shift register are ever shifted on,
  // so the top byte is not stored; the full word is captured directly.
  logic [SR_W-1:0]    sr;
  logic [1:0]         byte_idx;
  logic [TO_W-1:0]    to_cnt;
  logic [INST_SZ-1:0] new_word;
  logic [MEM_SZ:0]    count_plus;

  logic clear_load;
  logic take_byte;
  logic load_word;
  logic to_inc;
  logic count_inc;

  assign new_word   = {sr, i_rx_data};
  assign count_plus = o_word_count + (MEM_SZ + 1)'(1);
  assign o_addr     = o_word_count[MEM_SZ-1:0];

  always_comb begin
    state_next = state;
    clear_load = 1'b0;
    take_byte  = 1'b0;
    load_word  = 1'b0;
    to_inc     = 1'b0;
    count_inc  = 1'b0;
    case (state)
      IDLE, DONE, ERROR: begin
        if (i_start) begin
          state_next = RECV;
          clear_load = 1'b1;
        end
      end
      RECV: begin
        if (i_rx_done) begin
          take_byte = 1'b1;
          if (byte_idx == 2'd3) begin
            load_word  = 1'b1;
            state_next = WRITE;
          end
        end else if (to_cnt == TO_LAST) begin
          state_next = ERROR;
        end else begin
          to_inc = 1'b1;
        end
      end
      WRITE: begin
        count_inc = 1'b1;
        if (o_instruction == HALT_INST) begin
          state_next = DONE;
        end else if (count_plus == CAPACITY) begin
          state_next = ERROR;
        end else begin
          state_next = RECV;
          // A byte arriving during the write cycle starts the next word.
          take_byte  = i_rx_done;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state         <= IDLE;
      sr            <= '0;
      byte_idx      <= '0;
      to_cnt        <= '0;
      o_word_count  <= '0;
      o_instruction <= '0;
      o_write       <= 1'b0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_error       <= 1'b0;
    end else begin
      state   <= state_next;
      o_write <= (state_next == WRITE);
      o_busy  <= (state_next == RECV) || (state_next == WRITE);
      o_done  <= (state_next == DONE);
      o_error <= (state_next == ERROR);

      if (clear_load) begin
        sr            <= '0;
        byte_idx      <= '0;
        to_cnt        <= '0;
        o_word_count  <= '0;
        o_instruction <= '0;
      end
      if (take_byte) begin
        sr       <= new_word[SR_W-1:0];
        byte_idx <= byte_idx + 2'd1;
        to_cnt   <= '0;
      end
      if (load_word) begin
        o_instruction <= new_word;
      end
      if (to_inc) begin
        to_cnt <= to_cnt + TO_W'(1);
      end
      if (count_inc) begin
        o_word_count <= count_plus;
      end
    end
  end

endmodule

// File: tb/tb_inst_loader.sv
// Bench for inst_loader: directed load/timeout/overflow/reset/restart cases plus
// randomized loads scored against a byte-stream reference model.
module tb_inst_loader;

  localparam int unsigned  MEM_SZ  = 2;
  localparam int unsigned  TIMEOUT = 16;
  localparam logic [31:0]  HALT    = 32'hFFFF_FFFF;
  localparam int           CAP     = 4;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_start = 1'b0;
  logic [7:0]  i_rx_data = '0;
  logic        i_rx_done = 1'b0;
  logic [31:0] o_instruction;
  logic        o_write;
  logic [MEM_SZ-1:0] o_addr;
  logic [MEM_SZ:0]   o_word_count;
  logic        o_busy;
  logic        o_done;
  logic        o_error;

  inst_loader #(
    .INST_SZ   (32),
    .BYTE_SZ   (8),
    .MEM_SZ    (MEM_SZ),
    .HALT_INST (HALT),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_start       (i_start),
    .i_rx_data     (i_rx_data),
    .i_rx_done     (i_rx_done),
    .o_instruction (o_instruction),
    .o_write       (o_write),
    .o_addr        (o_addr),
    .o_word_count  (o_word_count),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_error       (o_error)
  );

  always #5 i_clk = ~i_clk;

  int unsigned cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int unsigned cyc;
  } wr_t;

  wr_t got_q[$];
  wr_t exp_q[$];

  always @(negedge i_clk) begin
    if (o_write) got_q.push_back('{32'(o_addr), o_instruction, cyc});
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: byte stream -> words -> writes until halt or full memory.
  logic [31:0] m_word;
  logic [31:0] m_last;
  int          m_nbytes;
  int          m_count;
  int          m_term;   // 0 running, 1 done, 2 error

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic model_clear();
    m_word   = '0;
    m_last   = '0;
    m_nbytes = 0;
    m_count  = 0;
    m_term   = 0;
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic do_start();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    model_clear();
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input bit with_start);
    repeat (gap) tick();
    i_rx_data = b;
    i_rx_done = 1'b1;
    i_start   = with_start && (m_term == 0);
    if (m_term == 0) begin
      m_word = {m_word[23:0], b};
      m_nbytes++;
      if (m_nbytes == 4) begin
        exp_q.push_back('{32'(m_count), m_word, cyc + 1});
        m_count++;
        m_nbytes = 0;
        m_last   = m_word;
        if (m_word == HALT)      m_term = 1;
        else if (m_count == CAP) m_term = 2;
      end
    end
    tick();
    i_rx_done = 1'b0;
    i_start   = 1'b0;
    i_rx_data = 8'($urandom);
  endtask

  task automatic send_word(input logic [31:0] w, input int first_gap, input bit rnd);
    logic [31:0] wv;
    wv = w;
    for (int i = 0; i < 4; i++) begin
      send_byte(wv[31-8*i -: 8],
                (i == 0) ? first_gap : (rnd ? int'($urandom_range(0, 3)) : 0),
                rnd && ($urandom_range(0, 7) == 0));
    end
  endtask

  task automatic check_result(input string tag);
    int n;
    repeat (3) tick();
    check({tag, ".nwr"}, 64'(got_q.size()), 64'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check({tag, ".addr"}, 64'(got_q[i].addr), 64'(exp_q[i].addr));
      check({tag, ".data"}, 64'(got_q[i].data), 64'(exp_q[i].data));
      check({tag, ".lat"},  64'(got_q[i].cyc),  64'(exp_q[i].cyc));
    end
    check({tag, ".done"},  64'(o_done),  64'(m_term == 1));
    check({tag, ".error"}, 64'(o_error), 64'(m_term == 2));
    check({tag, ".busy"},  64'(o_busy),  64'(m_term == 0));
    check({tag, ".count"}, 64'(o_word_count), 64'(m_count));
    if (m_count > 0) check({tag, ".instr"}, 64'(o_instruction), 64'(m_last));
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".instr"}, 64'(o_instruction), 64'h0);
    check({tag, ".count"}, 64'(o_word_count), 64'h0);
    check({tag, ".flags"}, 64'({o_write, o_addr, o_busy, o_done, o_error}), 64'h0);
  endtask

  initial begin
    logic [31:0] w;
    int          nw;
    model_clear();

    repeat (3) tick();
    check_zero("reset");
    i_reset = 1'b1;
    tick();

    // Bytes while idle must not produce anything
    for (int i = 0; i < 4; i++) begin
      i_rx_data = 8'($urandom);
      i_rx_done = 1'b1;
      tick();
      i_rx_done = 1'b0;
    end
    repeat (2) tick();
    check("idle.nwr", 64'(got_q.size()), 64'h0);
    check_zero("idle");

    do_start();
    send_word(32'h2008_0005, 1, 1'b0);
    send_word(32'h8C01_0004, 2, 1'b0);
    send_word(HALT, 0, 1'b0);
    check_result("load3");

    do_start();
    check("restart.done",  64'(o_done), 64'h0);
    check("restart.count", 64'(o_word_count), 64'h0);
    check("restart.busy",  64'(o_busy), 64'h1);
    send_word(32'h1234_5678, 0, 1'b0);
    send_word(32'hA5B6_C7D8, 0, 1'b0);
    send_word(HALT, 0, 1'b0);
    check_result("collide");

    do_start();
    send_word(32'h0000_0001, 0, 1'b0);
    send_word(32'h0000_0002, 1, 1'b0);
    send_word(32'h0000_0003, 0, 1'b0);
    send_word(32'h0000_0004, 2, 1'b0);
    send_word(32'h0000_0005, 0, 1'b0);
    check_result("ovf");

    do_start();
    send_byte(8'h11, 0, 1'b0);
    send_byte(8'h22, 0, 1'b0);
    repeat (14) tick();
    check("tmo.early_err",  64'(o_error), 64'h0);
    check("tmo.early_busy", 64'(o_busy),  64'h1);
    repeat (2) tick();
    check("tmo.error", 64'(o_error), 64'h1);
    check("tmo.busy",  64'(o_busy),  64'h0);
    check("tmo.count", 64'(o_word_count), 64'h0);
    check("tmo.nwr",   64'(got_q.size()), 64'h0);

    do_start();
    send_word(32'hDEAD_BEEF, 0, 1'b0);
    send_byte(8'h33, 1, 1'b0);
    send_byte(8'h44, 0, 1'b0);
    i_reset = 1'b0;
    tick();
    check_zero("midrst");
    i_reset = 1'b1;
    repeat (4) tick();
    check("midrst.nwr", 64'(got_q.size()), 64'(exp_q.size()));
    do_start();
    send_word(32'h0BAD_F00D, 0, 1'b0);
    send_word(HALT, 1, 1'b0);
    check_result("postrst");

    for (int t = 0; t < 25; t++) begin
      do_start();
      nw = int'($urandom_range(1, 6));
      for (int k = 0; k < nw; k++) begin
        w = $urandom;
        if (w == HALT) w = 32'h0;
        if ($urandom_range(0, 4) == 0) w = HALT;
        send_word(w, int'($urandom_range(0, 4)), 1'b1);
      end
      if (m_term == 0) send_word(HALT, 0, 1'b1);
      check_result("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
